// File: rtl/sfp_frame_dispatcher.sv
// sfp_frame_dispatcher: latches one RX frame, dispatches it to the handler named by its command byte,
// and forwards the response (or an error frame) to TX before releasing the RX buffer.
module sfp_frame_dispatcher #(
  parameter int C_DATA_FRAME_BIT = 64,
  parameter int C_NUM_HANDLER    = 4,
  parameter int C_TIMEOUT        = 1000
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [C_DATA_FRAME_BIT-1:0]               i_rx_frame,
  input  logic                                      i_rx_valid,
  output logic                                      o_rx_clr,
  output logic [C_DATA_FRAME_BIT-1:0]               o_hdl_frame,
  output logic [C_NUM_HANDLER-1:0]                  o_hdl_valid,
  input  logic [C_NUM_HANDLER-1:0]                  i_hdl_done,
  input  logic [C_NUM_HANDLER*C_DATA_FRAME_BIT-1:0] i_hdl_frame,
  output logic [C_DATA_FRAME_BIT-1:0]               o_tx_frame,
  output logic                                      o_tx_valid,
  input  logic                                      i_tx_ready,
  output logic                                      o_busy,
  output logic                                      o_timeout,
  output logic [15:0]                               o_err_cnt
);
  localparam int W  = C_DATA_FRAME_BIT;
  localparam int IW = C_NUM_HANDLER > 1 ? $clog2(C_NUM_HANDLER) : 1;
  localparam int TW = $clog2(C_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_TX, S_CLR} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    rx_q, rx_d, tx_q, tx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     err_q, err_d;
  logic            timeout_q, timeout_d, err_inc;
  logic [7:0]      cmd;
  logic [IW-1:0]   idx;
  logic            known, done_sel, expired;
  logic [W-1:0]    resp;

  assign cmd      = rx_q[W-1 -: 8];
  assign idx      = cmd[IW-1:0];
  assign known    = 32'(cmd) < C_NUM_HANDLER;
  assign done_sel = i_hdl_done[idx];
  assign expired  = timer_q == TW'(C_TIMEOUT - 1);
  assign resp     = i_hdl_frame[idx*W +: W];
  assign err_d    = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      rx_q      <= '0;
      tx_q      <= '0;
      timer_q   <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    err_inc   = 1'b0;
    case (state_q)
      S_IDLE: if (i_rx_valid) begin
        rx_d    = i_rx_frame;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        timer_d = '0;
        state_d = known ? S_WAIT : S_TX;
        if (!known) begin
          tx_d    = W'({8'hEE, cmd}) << (W - 16);
          err_inc = 1'b1;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // a done arriving in the expiry cycle still wins over the timeout
        if (done_sel) begin
          tx_d    = resp;
          state_d = S_TX;
        end else if (expired) begin
          tx_d      = W'({8'hEF, cmd}) << (W - 16);
          timeout_d = 1'b1;
          err_inc   = 1'b1;
          state_d   = S_TX;
        end
      end
      S_TX:    if (i_tx_ready) state_d = S_CLR;
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = state_q != S_IDLE;
    o_tx_valid  = state_q == S_TX;
    o_rx_clr    = state_q == S_CLR;
    o_hdl_valid = (state_q == S_WAIT) ? C_NUM_HANDLER'(1) << idx : '0;
    o_hdl_frame = rx_q;
    o_tx_frame  = tx_q;
    o_timeout   = timeout_q;
    o_err_cnt   = err_q;
  end
endmodule

// File: tb/tb_sfp_frame_dispatcher.sv
// tb_sfp_frame_dispatcher: directed plus randomized transactions checked against a
// transaction-level model of dispatch latency, response selection, timeouts and error counting.
module tb_sfp_frame_dispatcher;
  localparam int W = 64;
  localparam int N = 4;
  localparam int T = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [W-1:0]   i_rx_frame = '0;
  logic           i_rx_valid = 1'b0;
  logic           o_rx_clr;
  logic [W-1:0]   o_hdl_frame;
  logic [N-1:0]   o_hdl_valid;
  logic [N-1:0]   i_hdl_done = '0;
  logic [N*W-1:0] i_hdl_frame = '0;
  logic [W-1:0]   o_tx_frame;
  logic           o_tx_valid;
  logic           i_tx_ready = 1'b0;
  logic           o_busy;
  logic           o_timeout;
  logic [15:0]    o_err_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_err = '0;

  sfp_frame_dispatcher #(.C_DATA_FRAME_BIT(W), .C_NUM_HANDLER(N), .C_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_rx_frame(i_rx_frame), .i_rx_valid(i_rx_valid),
    .o_rx_clr(o_rx_clr), .o_hdl_frame(o_hdl_frame), .o_hdl_valid(o_hdl_valid),
    .i_hdl_done(i_hdl_done), .i_hdl_frame(i_hdl_frame), .o_tx_frame(o_tx_frame),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_busy(o_busy),
    .o_timeout(o_timeout), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // dly = WAIT-cycle index in which the handler pulses done; dly >= T means it never answers
  task automatic run_txn(input logic [7:0] cmd, input logic [55:0] pay, input logic [63:0] resp,
                         input int dly, input int rdy, input bit noise);
    bit          known, bad_hv, bad_hold;
    int          hv, tos, exp_hv, exp_to, budget, first_at;
    logic [63:0] exp_tx;
    known = cmd < N;
    bad_hv = 0; bad_hold = 0; hv = 0; tos = 0; budget = 0; first_at = 0;
    exp_to = (known && dly >= T) ? 1 : 0;
    if (known && dly < T) begin
      exp_hv = dly + 1;
      exp_tx = resp;
    end else begin
      exp_hv = known ? T : 0;
      exp_tx = {known ? 8'hEF : 8'hEE, cmd, 48'h0};
      exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
    end
    check("idle_busy", 64'(o_busy), 64'd0);
    i_rx_frame = {cmd, pay};
    i_rx_valid = 1'b1;
    @(negedge clk);
    check("decode_outs", 64'({o_busy, o_hdl_valid, o_tx_valid}), 64'({1'b1, 4'b0, 1'b0}));
    check("hdl_frame", o_hdl_frame, {cmd, pay});
    while (!o_tx_valid && budget < T + 20) begin
      @(negedge clk);
      budget++;
      tos += int'(o_timeout);
      i_hdl_done = noise ? N'($urandom) : '0;
      if (known) i_hdl_done[cmd] = 1'b0;
      for (int k = 0; k < N; k++)
        if (!known || k != int'(cmd)) i_hdl_frame[k*W +: W] = {$urandom, $urandom};
      if (o_hdl_valid != '0) begin
        hv++;
        if (hv == 1) first_at = budget;
        if (!known || o_hdl_valid != (N'(1) << cmd)) bad_hv = 1;
        if (known && hv - 1 == dly) begin
          i_hdl_done[cmd] = 1'b1;
          i_hdl_frame[int'(cmd)*W +: W] = resp;
        end
      end
    end
    i_hdl_done = '0;
    check("tx_valid_seen", 64'(o_tx_valid), 64'd1);
    check("tx_latency", 64'(budget), 64'(exp_hv + 1));
    check("hv_latency", 64'(first_at), known ? 64'd1 : 64'd0);
    check("hv_cycles", 64'(hv), 64'(exp_hv));
    check("hv_onehot", 64'(bad_hv), 64'd0);
    check("tx_frame", o_tx_frame, exp_tx);
    check("err_cnt", 64'(o_err_cnt), 64'(exp_err));
    repeat (rdy) begin
      @(negedge clk);
      tos += int'(o_timeout);
      if (!o_tx_valid || o_tx_frame !== exp_tx || o_rx_clr || o_hdl_valid != '0) bad_hold = 1;
    end
    i_tx_ready = 1'b1;
    @(negedge clk);
    tos += int'(o_timeout);
    check("tx_hold", 64'(bad_hold), 64'd0);
    check("clr_pulse", 64'({o_rx_clr, o_tx_valid}), 64'b10);
    i_tx_ready = 1'b0;
    i_rx_valid = 1'b0;
    @(negedge clk);
    check("post_clr", 64'({o_rx_clr, o_busy, o_timeout}), 64'd0);
    check("timeouts", 64'(tos), 64'(exp_to));
  endtask

  initial begin
    int r, d;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_outs", 64'({o_busy, o_hdl_valid, o_tx_valid, o_rx_clr, o_timeout}), 64'd0);
    check("rst_err", 64'(o_err_cnt), 64'd0);
    check("rst_frames", o_tx_frame | o_hdl_frame, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(8'h01, 56'h00_0000_0000_0001, 64'h0000_0000_0000_FFFF, 4, 0, 0);
    run_txn(8'h07, 56'h12_3456_789A_BCDE, 64'h0, 0, 0, 0);
    run_txn(8'h02, 56'h0, 64'h0, T + 5, 0, 0);
    run_txn(8'h00, 56'hAB_CDEF_0000_1111, 64'hDEAD_BEEF_CAFE_F00D, T - 1, 1, 1);
    run_txn(8'h03, 56'h55_5555_5555_5555, 64'h1234_5678_9ABC_DEF0, 3, 20, 1);
    i_rx_frame = 64'h0100_0000_0000_0042;
    i_rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_hv", 64'(o_hdl_valid), 64'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", 64'({o_busy, o_hdl_valid, o_tx_valid, o_rx_clr}), 64'd0);
    check("async_rst_err", 64'(o_err_cnt), 64'd0);
    i_rx_valid = 1'b0;
    exp_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_clr", 64'({o_rx_clr, o_busy}), 64'd0);
    run_txn(8'h01, 56'h00_0000_0000_0099, 64'h0F0F_0F0F_0F0F_0F0F, 2, 0, 0);
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      d = (r == 0) ? T - 1 : (r == 1) ? T + 5 : $urandom_range(0, 15);
      run_txn(8'($urandom_range(0, 7)), {$urandom, 24'($urandom)}, {$urandom, $urandom},
              d, $urandom_range(0, 5), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sfp_frame_dispatcher.md
Name: sfp_frame_dispatcher

Overview:
- Command scheduler between the SFP frame receive path and the per-function frame handlers, such as the LED test handler.
- Latches one received frame and decodes its command byte.
- Hands the frame to exactly one handler and waits for that handler's done handshake, with a timeout.
- Forwards the handler's response frame to the SFP transmit path, then clears the receive buffer.

Parameters:
C_DATA_FRAME_BIT, 64, frame width in bits (must be >= 16)
C_NUM_HANDLER, 4, number of handler slots (1..16)
C_TIMEOUT, 1000, cycles to wait for handler done before aborting (>= 2)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_rx_frame  in  C_DATA_FRAME_BIT  received frame from SFP RX buffer
i_rx_valid  in  1  received frame available (level)
o_rx_clr  out  1  one-cycle pulse: RX buffer may be cleared
o_hdl_frame  out  C_DATA_FRAME_BIT  latched frame broadcast to all handlers
o_hdl_valid  out  C_NUM_HANDLER  one-hot frame-valid to the selected handler (level)
i_hdl_done  in  C_NUM_HANDLER  per-handler done pulse
i_hdl_frame  in  C_NUM_HANDLER*C_DATA_FRAME_BIT  per-handler response frames; slot k at [k*W +: W]
o_tx_frame  out  C_DATA_FRAME_BIT  response frame to SFP TX
o_tx_valid  out  1  response valid (valid/ready handshake)
i_tx_ready  in  1  TX path accepts frame
o_busy  out  1  high in every state except IDLE
o_timeout  out  1  one-cycle pulse on handler timeout
o_err_cnt  out  16  saturating count of unknown-command plus timeout events

Behaviour:
- Reset is asynchronous and active-low. All outputs, state and counters go to 0 immediately; state goes to IDLE. A reset mid-operation aborts the transaction and drops any pending valid, with no clr pulse.
- cmd = rx_reg[W-1:W-8]. idx = cmd when cmd < C_NUM_HANDLER.
- FSM states: IDLE, DECODE, WAIT, TX, CLR.
- IDLE:
  - On i_rx_valid=1, latch i_rx_frame into rx_reg. o_hdl_frame reflects rx_reg.
  - Go to DECODE.
- DECODE (1 cycle):
  - If cmd < C_NUM_HANDLER: set o_hdl_valid[idx]=1, clear the timer, go to WAIT.
  - Otherwise: load tx_reg = {8'hEE, cmd, zeros}, increment o_err_cnt, go to TX.
- WAIT:
  - The timer increments each cycle.
  - If i_hdl_done[idx]=1: capture the slot-idx frame into tx_reg, clear o_hdl_valid, go to TX.
  - Else if timer == C_TIMEOUT-1: load tx_reg = {8'hEF, cmd, zeros}, clear o_hdl_valid, pulse o_timeout, increment o_err_cnt, go to TX.
  - done on the same cycle as the timeout wins; no timeout is recorded.
  - done bits from non-selected handlers are ignored in all states.
- TX:
  - o_tx_valid=1 and o_tx_frame=tx_reg, held stable until i_tx_ready=1.
  - On the handshake, o_tx_valid drops on the next edge; go to CLR.
  - No timeout applies in TX; the block waits indefinitely.
- CLR (1 cycle): o_rx_clr=1, then return to IDLE.
  - Upstream deasserts i_rx_valid in response to o_rx_clr, so IDLE sees it low no earlier than the cycle after CLR.
  - A new frame that is valid in that first IDLE cycle is accepted immediately.
- Latency, valid frame to o_hdl_valid: 2 edges (IDLE→DECODE→WAIT).
- Latency, handler done to o_tx_valid: 1 edge.
- o_err_cnt saturates at 16'hFFFF.
- Frames arriving while busy are not sampled; they remain pending in the RX buffer.
- Only one transaction is in flight at any time.

Test Plan:
1. Reset then frame 64'h0100_0000_0000_0001; handler 1 pulses done 5 cycles later with response 64'h0000_0000_0000_FFFF; i_tx_ready=1 → o_hdl_valid=4'b0010 two edges after valid, o_tx_frame=64'h0000_0000_0000_FFFF, single o_rx_clr pulse, o_err_cnt=0.
2. Frame with cmd=8'h07 (C_NUM_HANDLER=4) → no o_hdl_valid, o_tx_frame=64'hEE07_0000_0000_0000, o_err_cnt=1.
3. cmd=2 and handler never responds (C_TIMEOUT=1000) → o_hdl_valid[2] drops after 1000 WAIT cycles, o_timeout pulses once, o_tx_frame=64'hEF02_0000_0000_0000.
4. Done arriving in the exact timeout cycle → handler response forwarded, no o_timeout, o_err_cnt unchanged.
5. i_tx_ready held low 20 cycles → o_tx_valid and o_tx_frame stable throughout, o_rx_clr only after ready; done pulses on handler 0 while idle-serving handler 3 are ignored.
6. Assert i_rst low during WAIT → o_hdl_valid, o_busy and o_tx_valid go 0 immediately; after release a fresh frame completes normally.
